// File: rtl/fifo_rr_read_scheduler.sv
// Round-robin burst read scheduler: drains NUM_QUEUES registered-output FIFOs into one tagged valid/ready stream.
// rd_en -> out_valid takes 2 cycles; a 2-entry buffer absorbs in-flight reads, and reads stop when it could overflow.
module fifo_rr_read_scheduler #(
   parameter int WIDTH      = 8,
   parameter int NUM_QUEUES = 4,
   parameter int MAX_BURST  = 4,
   localparam int SW        = $clog2(NUM_QUEUES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_QUEUES-1:0]       fifo_empty,
   input  logic [NUM_QUEUES*WIDTH-1:0] fifo_dout,
   output logic [NUM_QUEUES-1:0]       fifo_rd_en,
   output logic [WIDTH-1:0]            out_data,
   output logic [SW-1:0]               out_src,
   output logic                        out_valid,
   input  logic                        out_ready
);
   localparam int BW = $clog2(MAX_BURST + 1);

   if (NUM_QUEUES < 2) begin : g_bad_num_queues
      $fatal(1, "fifo_rr_read_scheduler: NUM_QUEUES must be >= 2");
   end
   if (MAX_BURST < 1) begin : g_bad_max_burst
      $fatal(1, "fifo_rr_read_scheduler: MAX_BURST must be >= 1");
   end

   logic [WIDTH-1:0] buf_dat_q [2];
   logic [WIDTH-1:0] buf_dat_d [2];
   logic [SW-1:0]    buf_src_q [2];
   logic [SW-1:0]    buf_src_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             pend_q, pend_d;
   logic [SW-1:0]    pend_src_q, pend_src_d;
   logic [SW-1:0]    last_q, last_d;
   logic [BW-1:0]    burst_q, burst_d;

   logic             pop;
   logic             any_cand;
   logic             keep;
   logic             rot_found;
   logic [SW-1:0]    rot_sel;
   logic [SW-1:0]    grant;
   logic             issue;

   assign out_valid = (occ_q != 2'd0) & ~rst;
   assign out_data  = buf_dat_q[rd_ptr_q];
   assign out_src   = buf_src_q[rd_ptr_q];

   // Grant and issue; out_ready feeds rd_en combinationally so a full-rate stream never bubbles.
   always_comb begin
      pop       = out_valid & out_ready;
      any_cand  = ~&fifo_empty;
      keep      = (burst_q != '0) && (burst_q < BW'(MAX_BURST)) && !fifo_empty[last_q];
      rot_found = 1'b0;
      rot_sel   = last_q;
      for (int k = 1; k <= NUM_QUEUES; k++) begin
         if (!rot_found && !fifo_empty[(int'(last_q) + k) % NUM_QUEUES]) begin
            rot_found = 1'b1;
            rot_sel   = SW'((int'(last_q) + k) % NUM_QUEUES);
         end
      end
      grant      = keep ? last_q : rot_sel;
      issue      = ~rst & any_cand & ((int'(occ_q) + int'(pend_q) - int'(pop)) <= 1);
      fifo_rd_en = '0;
      if (issue) begin
         fifo_rd_en[grant] = 1'b1;
      end
   end

   always_comb begin
      buf_dat_d  = buf_dat_q;
      buf_src_d  = buf_src_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q + 2'(pend_q) - 2'(pop);
      pend_d     = issue;
      pend_src_d = grant;
      last_d     = last_q;
      burst_d    = burst_q;
      if (pend_q) begin
         buf_dat_d[wr_ptr_q] = fifo_dout[int'(pend_src_q)*WIDTH +: WIDTH];
         buf_src_d[wr_ptr_q] = pend_src_q;
         wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      // A stall leaves the burst alone, but an emptied queue forfeits the rest of its burst.
      if (issue) begin
         last_d  = grant;
         burst_d = keep ? burst_q + BW'(1) : BW'(1);
      end else if (fifo_empty[last_q]) begin
         burst_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            buf_dat_q[i] <= '0;
            buf_src_q[i] <= '0;
         end
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
         pend_q     <= 1'b0;
         pend_src_q <= '0;
         last_q     <= SW'(NUM_QUEUES - 1);
         burst_q    <= '0;
      end else begin
         buf_dat_q  <= buf_dat_d;
         buf_src_q  <= buf_src_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         pend_q     <= pend_d;
         pend_src_q <= pend_src_d;
         last_q     <= last_d;
         burst_q    <= burst_d;
      end
   end

endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// Bench for fifo_rr_read_scheduler: behavioural FIFOs feed the DUT, a negedge monitor checks every output
// against per-queue scoreboards, an issue-order queue and a round-robin burst reference model.
module tb_fifo_rr_read_scheduler;
   localparam int W  = 8;
   localparam int NQ = 4;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NQ-1:0]   fifo_empty;
   logic [NQ*W-1:0] fifo_dout;
   logic [NQ-1:0]   fifo_rd_en;
   logic [W-1:0]    out_data;
   logic [1:0]      out_src;
   logic            out_valid;
   logic            out_ready;

   fifo_rr_read_scheduler #(.WIDTH(W), .NUM_QUEUES(NQ), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W-1:0] mem   [NQ][$];
   logic [W-1:0] exp_q [NQ][$];
   logic [NQ-1:0] rd_s = '0;

   int inflight = 0;
   int m_last   = NQ - 1;
   int m_cnt    = 0;
   int iss_q[$];
   int iss_cyc_log[$];
   int iss_src_log[$];
   int xf_cyc_log[$];
   int xf_src_log[$];
   logic [W-1:0] xf_dat_log[$];
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_dat;
   logic [1:0]   prev_src;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic upd_empty();
      for (int i = 0; i < NQ; i++) fifo_empty[i] = (mem[i].size() == 0);
   endtask

   task automatic push(input int q, input logic [W-1:0] v);
      mem[q].push_back(v);
      exp_q[q].push_back(v);
      upd_empty();
   endtask

   task automatic clear_logs();
      iss_cyc_log.delete(); iss_src_log.delete();
      xf_cyc_log.delete();  xf_src_log.delete(); xf_dat_log.delete();
   endtask

   // One clock cycle: the FIFOs answer last cycle's reads, then the new rst/out_ready are applied.
   task automatic tick(input logic r, input logic rdy);
      @(posedge clk);
      #1;
      for (int i = 0; i < NQ; i++) begin
         if (rd_s[i]) begin
            if (mem[i].size() > 0) fifo_dout[i*W +: W] = mem[i].pop_front();
            else fifo_dout[i*W +: W] = '0;
         end
      end
      rst       = r;
      out_ready = rdy;
      if (r) begin
         for (int i = 0; i < NQ; i++) begin
            mem[i].delete();
            exp_q[i].delete();
         end
      end
      upd_empty();
   endtask

   always @(negedge clk) begin : monitor
      int g, pred;
      bit pop, iss, exp_iss, kept;
      cyc++;
      rd_s = fifo_rd_en;
      if (rst) begin
         check("rst_rd_en", fifo_rd_en, 0);
         check("rst_out_valid", out_valid, 0);
         inflight   = 0;
         m_last     = NQ - 1;
         m_cnt      = 0;
         prev_stall = 1'b0;
         iss_q.delete();
      end else begin
         pop     = out_valid && out_ready;
         iss     = (fifo_rd_en != '0);
         exp_iss = (fifo_empty != '1) && (inflight - int'(pop) <= 1);
         check("issue_cond", iss, exp_iss);
         if (prev_stall) begin
            check("hold_data", out_data, prev_dat);
            check("hold_src", out_src, prev_src);
         end
         if (fifo_empty[m_last]) m_cnt = 0;
         if (iss) begin
            g = 0;
            for (int i = 0; i < NQ; i++) if (fifo_rd_en[i]) g = i;
            check("rd_onehot", $onehot(fifo_rd_en), 1);
            check("rd_on_empty", fifo_empty[g], 0);
            kept = (m_cnt > 0) && (m_cnt < MB) && !fifo_empty[m_last];
            pred = m_last;
            if (!kept) begin
               for (int k = NQ; k >= 1; k--) if (!fifo_empty[(m_last + k) % NQ]) pred = (m_last + k) % NQ;
            end
            check("grant", g, pred);
            m_cnt  = (kept && g == m_last) ? m_cnt + 1 : 1;
            m_last = g;
            iss_q.push_back(g);
            iss_cyc_log.push_back(cyc);
            iss_src_log.push_back(g);
         end
         if (pop) begin
            if (iss_q.size() == 0) check("xfer_unexpected", 1, 0);
            else check("xfer_issue_order", out_src, iss_q.pop_front());
            if (exp_q[out_src].size() == 0) check("xfer_no_word", 1, 0);
            else check("xfer_data", out_data, exp_q[out_src].pop_front());
            xf_cyc_log.push_back(cyc);
            xf_src_log.push_back(int'(out_src));
            xf_dat_log.push_back(out_data);
         end
         inflight   = inflight + int'(iss) - int'(pop);
         prev_stall = out_valid && !out_ready;
         prev_dat   = out_data;
         prev_src   = out_src;
      end
   end

   initial begin
      int exp_src[$];
      logic [W-1:0] words[$];
      rst        = 1'b1;
      out_ready  = 1'b0;
      fifo_dout  = '0;
      fifo_empty = '1;

      // Reset held with every queue loaded, then a 4x6-word full-rate drain.
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, 1'b0);
         for (int q = 0; q < NQ; q++)
            for (int k = 0; k < 6; k++) push(q, W'(q * 32 + k));
      end
      clear_logs();
      for (int i = 0; i < 100 && xf_src_log.size() < 24; i++) tick(1'b0, 1'b1);
      check("t3_count", xf_src_log.size(), 24);
      if (iss_src_log.size() > 0) check("t1_first_q0", iss_src_log[0], 0);
      foreach (exp_src[i]) exp_src.delete(i);
      for (int q = 0; q < NQ; q++) for (int k = 0; k < 4; k++) exp_src.push_back(q);
      for (int q = 0; q < NQ; q++) for (int k = 0; k < 2; k++) exp_src.push_back(q);
      if (xf_src_log.size() == 24) begin
         for (int i = 0; i < 24; i++) check("t3_src_order", xf_src_log[i], exp_src[i]);
         check("t3_continuous", xf_cyc_log[23] - xf_cyc_log[0], 23);
      end

      // Single queue, three words at full rate.
      tick(1'b0, 1'b1);
      clear_logs();
      push(1, 8'hA1); push(1, 8'hB2); push(1, 8'hC3);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      check("t2_issue_cnt", iss_src_log.size(), 3);
      check("t2_xfer_cnt", xf_src_log.size(), 3);
      if (iss_src_log.size() == 3 && xf_src_log.size() == 3) begin
         words = '{8'hA1, 8'hB2, 8'hC3};
         for (int i = 0; i < 3; i++) begin
            check("t2_rd_q1", iss_src_log[i], 1);
            check("t2_rd_cycle", iss_cyc_log[i], iss_cyc_log[0] + i);
            check("t2_latency", xf_cyc_log[i], iss_cyc_log[i] + 2);
            check("t2_src", xf_src_log[i], 1);
            check("t2_data", xf_dat_log[i], words[i]);
         end
      end

      // Backpressure: only two reads may be in flight, then release.
      tick(1'b0, 1'b0);
      clear_logs();
      words.delete();
      for (int k = 0; k < 8; k++) begin
         words.push_back(W'(8'h50 + k));
         push(0, W'(8'h50 + k));
      end
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
      check("t4_reads_stalled", iss_src_log.size(), 2);
      for (int i = 0; i < 40 && xf_dat_log.size() < 8; i++) tick(1'b0, 1'b1);
      check("t4_xfer_cnt", xf_dat_log.size(), 8);
      if (xf_dat_log.size() == 8)
         for (int i = 0; i < 8; i++) check("t4_order", xf_dat_log[i], words[i]);

      // Random arrivals and random backpressure.
      for (int c = 0; c < 10000; c++) begin
         tick(1'b0, ($urandom_range(0, 3) != 0));
         for (int q = 0; q < NQ; q++)
            if (mem[q].size() < 12 && $urandom_range(0, 5) == 0) push(q, W'($urandom));
      end
      for (int i = 0; i < 300; i++) tick(1'b0, 1'b1);
      for (int q = 0; q < NQ; q++) check("t5_drained", exp_q[q].size(), 0);
      check("t5_inflight", inflight, 0);

      // Reset with one word buffered and one read in flight: both are dropped.
      tick(1'b0, 1'b0);
      clear_logs();
      push(2, 8'hE1); push(2, 8'hE2);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      check("t6_reads_before_rst", iss_src_log.size(), 2);
      tick(1'b0, 1'b1);
      @(negedge clk);
      #1;
      check("t6_valid_after_rst", out_valid, 0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      check("t6_no_output", xf_dat_log.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
